// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch control in front of a memory
// with a one-cycle synchronous read. It delivers {pc, instruction} to decode
// over a valid/stall handshake and handles jumps, HALT and resume.
//
// Handshake: instr_valid marks a real word on instr_out/pc_out. A transfer
// ("accept") happens on a cycle with instr_valid & !stall. While stalled,
// the word and its pc stay stable, and decode keeps jump_en/jump_target
// steady until the accept.
module fetch_sequencer #(
  parameter int               ADDR_W   = 6,
  parameter int               INSTR_W  = 10,
  parameter int               OPC_W    = 4,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'hF,
  parameter int               RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               resume,
  output logic               halted,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   address_n, pc_n;
  logic [INSTR_W-1:0]  hold_reg, hold_reg_n;
  logic                hold_flag, hold_flag_n;
  logic [INSTR_W-1:0]  cur_instr;
  logic                accept;
  logic                is_halt;

  assign state_dbg = state;

  // Output decode, handshake and next-state computation.
  always_comb begin
    state_n     = state;
    address_n   = address;
    pc_n        = pc_out;
    hold_reg_n  = hold_reg;
    hold_flag_n = hold_flag;

    instr_valid = (state == S_RUN);
    halted      = (state == S_HALT);
    // Once stalled, the memory has moved on to the next word, so the held
    // copy is the one decode must keep seeing.
    cur_instr   = hold_flag ? hold_reg : instruction;
    instr_out   = instr_valid ? cur_instr : '0;
    accept      = instr_valid & ~stall;
    is_halt     = (cur_instr[INSTR_W-1 -: OPC_W] == HALT_OPC);

    unique case (state)
      S_FILL: begin
        // The word for 'address' arrives next cycle; whatever arrives now
        // belongs to a flushed or stale fetch.
        pc_n        = address;
        address_n   = address + ADDR_W'(1);
        hold_flag_n = 1'b0;
        state_n     = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          hold_flag_n = 1'b0;
          if (is_halt) begin
            // HALT wins over a simultaneous jump; address stays at pc+1.
            state_n = S_HALT;
          end else if (jump_en) begin
            address_n = jump_target;
            state_n   = S_FILL;
          end else begin
            pc_n      = address;
            address_n = address + ADDR_W'(1);
          end
        end else if (!hold_flag) begin
          hold_reg_n  = instruction;
          hold_flag_n = 1'b1;
        end
      end
      S_HALT: begin
        if (resume) state_n = S_FILL;
      end
      default: state_n = S_FILL;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FILL;
      address   <= ADDR_W'(RESET_PC);
      pc_out    <= ADDR_W'(RESET_PC);
      hold_reg  <= '0;
      hold_flag <= 1'b0;
    end else begin
      state     <= state_n;
      address   <= address_n;
      pc_out    <= pc_n;
      hold_reg  <= hold_reg_n;
      hold_flag <= hold_flag_n;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a behavioural memory, directed scenarios,
// randomized handshake traffic and a scoreboard monitor that predicts the
// delivered {pc, word} stream from the program-flow rules.
module tb_fetch_sequencer;

  localparam int W = 16;  // {pc[5:0], instr[9:0]}

  logic       clk;
  logic       rst_n;
  logic [5:0] address;
  logic [9:0] instruction;
  logic [9:0] instr_out;
  logic [5:0] pc_out;
  logic       instr_valid;
  logic       stall;
  logic       jump_en;
  logic [5:0] jump_target;
  logic       resume;
  logic       halted;
  logic [1:0] state_dbg;

  logic [9:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;
  int accepts  = 0;

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .instruction (instruction),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .resume      (resume),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  // Clock and the synchronous-read memory.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial instruction = '0;
  always @(posedge clk) instruction <= mem[address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected {pc, word} stream plus bubble/halt expectations.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [5:0]   e_pc, npc, halt_pc;
  logic         seeded, in_halt;
  int           gap_cnt, exp_gap;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      seeded  = 1'b0;
      in_halt = 1'b0;
      gap_cnt = 0;
      exp_gap = 1;
    end else begin
      if (!seeded) begin
        exp_q.push_back({6'd0, mem[0]});
        seeded = 1'b1;
      end
      check("halted", {31'd0, halted}, {31'd0, in_halt});
      if (in_halt) check("halt_addr", {26'd0, address}, {26'd0, halt_pc + 6'd1});
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got pc %0h with nothing expected", pc_out);
        end else begin
          e    = exp_q[0];
          e_pc = e[15:10];
          check("pc_out", {26'd0, pc_out}, {26'd0, e_pc});
          check("instr_out", {22'd0, instr_out}, {22'd0, e[9:0]});
          check("gap", gap_cnt, exp_gap);
          check("run_addr", {26'd0, address}, {26'd0, e_pc + 6'd1});
          exp_gap = 0;
          if (!stall) begin
            void'(exp_q.pop_front());
            accepts++;
            npc = e_pc + 6'd1;
            if (e[9:6] == 4'hF) begin
              in_halt = 1'b1;
              halt_pc = e_pc;
              exp_q.push_back({npc, mem[npc]});
              exp_gap = 1;
            end else if (jump_en) begin
              exp_q.push_back({jump_target, mem[jump_target]});
              exp_gap = 1;
            end else begin
              exp_q.push_back({npc, mem[npc]});
            end
          end
        end
        gap_cnt = 0;
      end else begin
        check("idle_instr", {22'd0, instr_out}, 32'd0);
        if (in_halt) gap_cnt = 0;
        else gap_cnt++;
        if (in_halt && resume) in_halt = 1'b0;
      end
    end
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [5:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (instr_valid && pc_out == target) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_pc: pc %0h never delivered (last pc %0h)", target, pc_out);
  endtask

  task automatic check_reset_outputs();
    check("rst_address", {26'd0, address}, 32'd0);
    check("rst_pc_out", {26'd0, pc_out}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {22'd0, instr_out}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
  endtask

  task automatic apply_reset(input bit randomize_mem);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    if (randomize_mem)
      for (int i = 0; i < 64; i++) mem[i] = 10'($urandom_range(0, 1023));
    stall = 1'b0; jump_en = 1'b0; resume = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic random_traffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      if (!stall) begin
        jump_en     = ($urandom_range(0, 3) == 0);
        jump_target = 6'($urandom_range(0, 63));
      end
      stall  = ($urandom_range(0, 2) == 0);
      resume = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_target = '0; resume = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 10'h040 + 10'(i);
    mem[7] = 10'h3C0;  // HALT opcode at pc 7

    // Reset, sequential run and a 3-cycle stall at pc 5.
    apply_reset(1'b0);
    wait_pc(6'd5, 10);
    stall = 1'b1;
    repeat (3) begin
      step();
      check("stall_addr", {26'd0, address}, 32'd6);
    end
    stall = 1'b0;

    // HALT at pc 7 with a simultaneous jump request, then resume.
    wait_pc(6'd7, 10);
    jump_en = 1'b1; jump_target = 6'd30;
    step();
    jump_en = 1'b0;
    repeat (5) step();
    check("halt_hold_addr", {26'd0, address}, 32'd8);
    resume = 1'b1;
    step();
    resume = 1'b0;

    // Jump from pc 10 to 20, then from 23 to 62 to cover the wrap.
    wait_pc(6'd10, 10);
    jump_en = 1'b1; jump_target = 6'd20;
    step();
    jump_en = 1'b0;
    wait_pc(6'd23, 10);
    jump_en = 1'b1; jump_target = 6'd62;
    step();
    jump_en = 1'b0;
    wait_pc(6'd2, 10);

    // Asynchronous reset in the middle of a stall with the hold copy live.
    wait_pc(6'd4, 10);
    stall = 1'b1;
    step();
    step();
    apply_reset(1'b0);
    wait_pc(6'd3, 10);
    jump_en = 1'b1; jump_target = 6'd20;
    step();
    jump_en = 1'b0;
    wait_pc(6'd21, 10);

    // Randomized traffic over random programs (random halts included).
    apply_reset(1'b1);
    random_traffic(600);
    apply_reset(1'b1);
    random_traffic(600);
    stall = 1'b0; jump_en = 1'b0; resume = 1'b1;
    repeat (4) step();

    n_checks++;
    if (accepts < 200) begin
      n_fail++;
      $display("FAIL accept_count: got %0d expected at least 200", accepts);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
